// File: rtl/sram_arbiter.sv
// sram_arbiter: merges an instruction-fetch port and a load/store port onto a
// single sram-like memory port, tracking up to OUTST_DEPTH outstanding
// transactions in an ID FIFO so responses are routed back in order.
//
// Parameters:
//   OUTST_DEPTH   max accepted-but-unanswered transactions (power of two, 2..8)
// Optional feature (macro SRAM_ARB_RR_EN):
//   defined   -> round-robin between inst and data on conflict
//   undefined -> fixed priority, data wins
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   inst_req/inst_addr             fetch request (word read)
//   inst_addr_ok/data_ok/rdata     fetch handshake and read data
//   data_req/data_req_bus          load/store request {wr,size,wstrb,addr,wdata}
//   data_addr_ok/data_ok/rdata     load/store handshake and read data
//   mem_req/mem_req_bus            shared port request, same bus layout
//   mem_addr_ok/data_ok/rdata      shared port handshake and read data
module sram_arbiter #(
  parameter int unsigned OUTST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [70:0] data_req_bus,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [70:0] mem_req_bus,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);
  localparam int unsigned CNT_W = $clog2(OUTST_DEPTH + 1);

  localparam logic [0:0] ID_INST = 1'b0;
  localparam logic [0:0] ID_DATA = 1'b1;

  logic                   r_locked;
  logic [0:0]             r_grant;
  logic [OUTST_DEPTH-1:0] r_ids;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
`ifdef SRAM_ARB_RR_EN
  logic [0:0]             r_last;
`endif

  logic       w_full;
  logic       w_empty;
  logic [0:0] w_sel;
  logic [0:0] w_grant;
  logic       w_push;
  logic       w_pop;
  logic [0:0] w_head;

  assign w_full  = (r_count == CNT_W'(OUTST_DEPTH));
  assign w_empty = (r_count == '0);

  // Requester selection used whenever the lock is not holding a grant.
  always_comb begin
    w_sel = r_grant;
    if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
      w_sel = (r_last == ID_DATA) ? ID_INST : ID_DATA;
`else
      w_sel = ID_DATA;
`endif
    end else if (data_req) begin
      w_sel = ID_DATA;
    end else if (inst_req) begin
      w_sel = ID_INST;
    end
  end

  assign w_grant = r_locked ? r_grant : w_sel;

  // Full blocks requests unconditionally: keeps mem_data_ok off the mem_req path.
  assign mem_req     = !w_full && (r_locked || inst_req || data_req);
  assign mem_req_bus = (w_grant == ID_INST) ?
                       {1'b0, 2'b10, 4'b0000, inst_addr, 32'b0} : data_req_bus;

  assign w_push = mem_req && mem_addr_ok;
  assign w_pop  = mem_data_ok && !w_empty;
  assign w_head = r_ids[r_rptr];

  assign inst_addr_ok = w_push && (w_grant == ID_INST);
  assign data_addr_ok = w_push && (w_grant == ID_DATA);
  assign inst_data_ok = w_pop && (w_head == ID_INST);
  assign data_data_ok = w_pop && (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Grant/lock: a request stalled by mem_addr_ok pins the grant until accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_locked <= 1'b0;
      r_grant  <= ID_DATA;
    end else begin
      r_grant <= w_grant;
      if (mem_req && !mem_addr_ok) begin
        r_locked <= 1'b1;
      end else if (mem_addr_ok) begin
        r_locked <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Last-accepted requester for round-robin conflict resolution.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last <= ID_DATA;
    end else if (w_push) begin
      r_last <= w_grant;
    end
  end
`endif

  // Outstanding-ID FIFO; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ids   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= w_grant;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
